// File: rtl/simon_support_unit.sv
// Simon support datapath: button debouncer, event counter
// and game-win animation sequencer.
module simon_support_unit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 5,
    parameter int ANIM_STEPS      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           btn_raw,
    output logic [3:0]           btn_vec,
    output logic                 btn_any,
    input  logic                 cnt_inc,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] cnt_val,
    input  logic                 anim_clr,
    input  logic                 anim_next,
    output logic [3:0]           anim_light,
    output logic [3:0]           anim_sound1,
    output logic [3:0]           anim_sound2,
    output logic                 anim_done
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [3:0] T1 = 4'b0000;
    localparam logic [3:0] T2 = 4'b0001;
    localparam logic [3:0] T3 = 4'b0010;
    localparam logic [3:0] T4 = 4'b0100;

    localparam logic [2:0] LAST = 3'(ANIM_STEPS - 1);

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  s_q;
    logic [3:0]                  s_nxt;
    logic                        stable;
    logic [DCW-1:0]              dc_q;

    logic       started_q;
    logic [2:0] idx_q;
    logic [3:0] tbl_light;
    logic [3:0] tbl_s1;
    logic [3:0] tbl_s2;

    // s_nxt is the value s takes at this edge; a run
    // counts only while it matches s and differs from
    // the committed vector.
    assign s_q    = sync_q[SYNC_STAGES-1];
    assign s_nxt  = sync_q[SYNC_STAGES-2];
    assign stable = (s_nxt == s_q) && (s_nxt != btn_vec);

    assign btn_any = |btn_vec;

    // Synchronizer chain for the raw buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Commit s to btn_vec after a full stable run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dc_q    <= '0;
            btn_vec <= '0;
        end else if (!stable) begin
            dc_q <= '0;
        end else if (dc_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
            dc_q    <= '0;
            btn_vec <= s_nxt;
        end else begin
            dc_q <= dc_q + 1'b1;
        end
    end

    // Event counter; clear wins over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_val <= '0;
        end else begin
            priority case (1'b1)
                cnt_clr: cnt_val <= '0;
                cnt_inc: cnt_val <= cnt_val + 1'b1;
                default: cnt_val <= cnt_val;
            endcase
        end
    end

    // Animation position; clear wins over next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            priority case (1'b1)
                anim_clr: begin
                    started_q <= 1'b0;
                    idx_q     <= '0;
                end
                anim_next: begin
                    if (!started_q) begin
                        started_q <= 1'b1;
                        idx_q     <= '0;
                    end else if (idx_q != LAST) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Step table lookup.
    always_comb begin
        tbl_light = 4'b0000;
        tbl_s1    = T1;
        tbl_s2    = T1;
        unique case (idx_q)
            3'd0: begin tbl_light = 4'b0001; tbl_s1 = T1; tbl_s2 = T3; end
            3'd1: begin tbl_light = 4'b0010; tbl_s1 = T2; tbl_s2 = T4; end
            3'd2: begin tbl_light = 4'b0100; tbl_s1 = T3; tbl_s2 = T1; end
            3'd3: begin tbl_light = 4'b1000; tbl_s1 = T4; tbl_s2 = T2; end
            3'd4: begin tbl_light = 4'b0011; tbl_s1 = T1; tbl_s2 = T2; end
            3'd5: begin tbl_light = 4'b1100; tbl_s1 = T3; tbl_s2 = T4; end
            3'd6: begin tbl_light = 4'b0101; tbl_s1 = T2; tbl_s2 = T3; end
            3'd7: begin tbl_light = 4'b1111; tbl_s1 = T4; tbl_s2 = T4; end
            default: ;
        endcase
    end

    // Register the animation outputs one cycle behind idx.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anim_light  <= '0;
            anim_sound1 <= '0;
            anim_sound2 <= '0;
            anim_done   <= 1'b0;
        end else begin
            anim_light  <= started_q ? tbl_light : 4'b0000;
            anim_sound1 <= started_q ? tbl_s1 : T1;
            anim_sound2 <= started_q ? tbl_s2 : T1;
            anim_done   <= started_q && (idx_q == LAST);
        end
    end

endmodule

// File: tb/tb_simon_support_unit.sv
// Scoreboard bench for simon_support_unit: stimulus pushes
// expected outputs, a monitor pops and compares each cycle.
module tb_simon_support_unit;

    localparam int SYNC  = 2;
    localparam int DEB   = 16;
    localparam int NSTEP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_vec;
    logic       btn_any;
    logic       cnt_inc;
    logic       cnt_clr;
    logic [4:0] cnt_val;
    logic       anim_clr;
    logic       anim_next;
    logic [3:0] anim_light;
    logic [3:0] anim_sound1;
    logic [3:0] anim_sound2;
    logic       anim_done;

    always #5 clk = ~clk;

    simon_support_unit dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_vec    (btn_vec),
        .btn_any    (btn_any),
        .cnt_inc    (cnt_inc),
        .cnt_clr    (cnt_clr),
        .cnt_val    (cnt_val),
        .anim_clr   (anim_clr),
        .anim_next  (anim_next),
        .anim_light (anim_light),
        .anim_sound1(anim_sound1),
        .anim_sound2(anim_sound2),
        .anim_done  (anim_done)
    );

    typedef struct packed {
        logic [3:0] vec;
        logic       any;
        logic [4:0] cnt;
        logic [3:0] light;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state.
    logic [3:0] rh[$];
    logic [3:0] m_vec;
    logic [4:0] m_cnt;
    int         m_steps;

    logic [3:0] tl [0:7] = '{4'h1, 4'h2, 4'h4, 4'h8,
                             4'h3, 4'hC, 4'h5, 4'hF};
    logic [3:0] t1 [0:7] = '{4'h0, 4'h1, 4'h2, 4'h4,
                             4'h0, 4'h2, 4'h1, 4'h4};
    logic [3:0] t2 [0:7] = '{4'h2, 4'h4, 4'h0, 4'h1,
                             4'h1, 4'h4, 4'h2, 4'h4};

    task automatic cmp(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_vec   = 4'h0;
        m_cnt   = 5'd0;
        m_steps = 0;
        rh.delete();
        repeat (SYNC + DEB) rh.push_back(4'h0);
    endtask

    // Apply one cycle of inputs (called at a negedge) and
    // predict the outputs after the coming rising edge.
    task automatic cyc(input logic [3:0] raw,
                       input logic inc, input logic clr,
                       input logic ac, input logic an);
        exp_t       e;
        int         n;
        int         i;
        logic [3:0] w;
        bit         same;
        btn_raw   = raw;
        cnt_inc   = inc;
        cnt_clr   = clr;
        anim_clr  = ac;
        anim_next = an;
        // Buttons: the value seen SYNC-1 samples ago must
        // have been steady for DEB+1 samples.
        rh.push_back(raw);
        n    = rh.size();
        w    = rh[n-SYNC];
        same = 1'b1;
        for (int k = 1; k <= DEB; k++)
            if (rh[n-SYNC-k] != w) same = 1'b0;
        if (same && w != m_vec) m_vec = w;
        if (n > 64) void'(rh.pop_front());
        // Counter.
        if (clr) m_cnt = 5'd0;
        else if (inc) m_cnt = m_cnt + 5'd1;
        // Animation shows the position before this edge.
        e.vec = m_vec;
        e.any = |m_vec;
        e.cnt = m_cnt;
        if (m_steps == 0) begin
            e.light = 4'h0;
            e.s1    = 4'h0;
            e.s2    = 4'h0;
            e.done  = 1'b0;
        end else begin
            i       = m_steps - 1;
            e.light = tl[i];
            e.s1    = t1[i];
            e.s2    = t2[i];
            e.done  = (i == NSTEP - 1);
        end
        if (ac) m_steps = 0;
        else if (an && m_steps < NSTEP) m_steps++;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic [3:0] raw);
        cyc(raw, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string nm);
        cmp({nm, "_btn"}, 32'({btn_vec, btn_any}), 32'd0);
        cmp({nm, "_cnt"}, 32'(cnt_val), 32'd0);
        cmp({nm, "_anim"},
            32'({anim_light, anim_sound1, anim_sound2, anim_done}),
            32'd0);
    endtask

    // Asynchronous reset between edges (called at a negedge).
    task automatic do_reset(input string nm);
        #1 reset = 1'b1;
        #1;
        chk_zero(nm);
        model_reset();
        #1 reset = 1'b0;
    endtask

    task automatic chk_anim(input string nm,
                            input logic [3:0] l,
                            input logic [3:0] a,
                            input logic [3:0] b,
                            input logic d);
        cmp(nm, 32'({anim_light, anim_sound1, anim_sound2, anim_done}),
            32'({l, a, b, d}));
    endtask

    // Monitor: every edge with a pending prediction is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("sb_btn", 32'({btn_vec, btn_any}),
                    32'({e.vec, e.any}));
                cmp("sb_cnt", 32'(cnt_val), 32'(e.cnt));
                cmp("sb_anim",
                    32'({anim_light, anim_sound1, anim_sound2, anim_done}),
                    32'({e.light, e.s1, e.s2, e.done}));
            end
        end
    end

    initial begin
        logic [3:0] cur;
        reset     = 1'b1;
        btn_raw   = 4'h0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        anim_clr  = 1'b0;
        anim_next = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Clean press: visible exactly 18 edges after change.
        for (int i = 1; i <= 30; i++) begin
            idle(4'b0100);
            if (i == 17)
                cmp("press_early", 32'({btn_vec, btn_any}), 32'd0);
            if (i == 18)
                cmp("press_on", 32'({btn_vec, btn_any}),
                    32'({4'b0100, 1'b1}));
        end
        repeat (25) idle(4'b0000);
        cmp("release", 32'({btn_vec, btn_any}), 32'd0);

        // Short glitch never reaches btn_vec.
        repeat (10) idle(4'b0001);
        for (int i = 0; i < 25; i++) begin
            idle(4'b0000);
            cmp("glitch", 32'({btn_vec, btn_any}), 32'd0);
        end

        // Counter wrap and clear priority.
        cyc(4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (33) cyc(4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4'h0);
        cmp("cnt_wrap", 32'(cnt_val), 32'd1);
        cyc(4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        cmp("cnt_clr_inc", 32'(cnt_val), 32'd0);

        // Animation walk through to the final step.
        cyc(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4'h0);
        chk_anim("anim_step0", 4'b0001, 4'h0, 4'h2, 1'b0);
        repeat (7) cyc(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4'h0);
        chk_anim("anim_step7", 4'b1111, 4'h4, 4'h4, 1'b1);
        cyc(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4'h0);
        chk_anim("anim_hold", 4'b1111, 4'h4, 4'h4, 1'b1);

        // Clear beats next.
        cyc(4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(4'h0);
        chk_anim("anim_clr_next", 4'h0, 4'h0, 4'h0, 1'b0);

        // Reset mid step 5, then restart at step 0.
        cyc(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (6) cyc(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4'h0);
        chk_anim("anim_step5", 4'b1100, 4'h2, 4'h4, 1'b0);
        do_reset("mid_rst");
        cyc(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4'h0);
        chk_anim("anim_restart", 4'b0001, 4'h0, 4'h2, 1'b0);

        // Randomized traffic against the model.
        cur = 4'h0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0)
                cur = 4'($urandom_range(0, 15));
            cyc(cur,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rand_rst");
                cur = 4'h0;
            end
        end

        @(posedge clk);
        #2;
        cmp("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
